// File: rtl/collision_pkg.sv
// Shared types and helpers for the billiard collision arbiter.
// Ball IDs, wall classification and the ball-pair indexing used by the seen bitmap.
package collision_pkg;

    localparam int unsigned DEFAULT_NUM_BALLS = 16;
    localparam int unsigned ID_W              = $clog2(DEFAULT_NUM_BALLS);

    typedef logic [ID_W-1:0] ball_id_t;

    typedef enum logic [1:0] {
        WALL_NONE   = 2'd0,
        WALL_VERT   = 2'd1,
        WALL_HORZ   = 2'd2,
        WALL_CORNER = 2'd3
    } wall_t;

    typedef struct packed {
        ball_id_t a;
        ball_id_t b;
    } pair_t;

    // Dense triangular index of pair (a,b), a<b, among n balls: 0 .. n*(n-1)/2-1.
    function automatic int unsigned pair_index(int unsigned a, int unsigned b, int unsigned n);
        return (a * (2 * n - a - 1)) / 2 + (b - a - 1);
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO for ball-ball pairs; push and pop in the same cycle both succeed even when full.
// The head output holds its last value while the FIFO is empty.
module pair_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last_q : mem_q[rd_q];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            last_q <= dout;
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (do_push) begin
                    mem_q[wr_q] <= din;
                    wr_q        <= wr_q + 1'b1;
                end
                if (do_pop) rd_q <= rd_q + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/collision_arbiter.sv
// Per-pixel collision detector and event arbiter: ball-ball pair queue, per-frame wall
// hits and pocket tracking, decided one register stage after the raster inputs.
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int unsigned NUM_BALLS  = DEFAULT_NUM_BALLS,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned HOLE_ID_W  = 3,
    localparam int unsigned BALL_ID_W = $clog2(NUM_BALLS)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   new_game,
    input  logic [NUM_BALLS-1:0]   balls_dr,
    input  logic [1:0]             table_dr,
    input  logic                   hole_dr,
    input  logic [HOLE_ID_W-1:0]   hole_id,
    output logic                   pair_valid,
    input  logic                   pair_ready,
    output logic [BALL_ID_W-1:0]   pair_id_a,
    output logic [BALL_ID_W-1:0]   pair_id_b,
    output logic                   pair_overflow,
    output logic [NUM_BALLS-1:0]   wall_pulse,
    output logic [2*NUM_BALLS-1:0] wall_side,
    output logic [NUM_BALLS-1:0]   balls_in_game,
    output logic                   pocket_valid,
    output logic [BALL_ID_W-1:0]   pocket_ball,
    output logic [HOLE_ID_W-1:0]   pocket_hole,
    output logic                   collision
);

    localparam int unsigned NUM_PAIRS = NUM_BALLS * (NUM_BALLS - 1) / 2;
    localparam int unsigned K_W       = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int unsigned PAIR_W    = 2 * BALL_ID_W;

    logic [NUM_BALLS-1:0]   act_now, act_q, act2, rest, hit;
    wall_t                  table_q;
    logic                   hole_q;
    logic [HOLE_ID_W-1:0]   hole_id_q;

    logic [NUM_BALLS-1:0]   bin_q, bin_d, acc_q, acc_d, acc_base, pulse_q, pulse_d;
    logic [2*NUM_BALLS-1:0] side_q, side_d, side_base, wside_q, wside_d;
    logic [NUM_PAIRS-1:0]   seen_q, seen_d, seen_base;
    logic                   ovf_q, ovf_d, pv_q, pv_d;
    logic [BALL_ID_W-1:0]   pball_q, pball_d, id_a, id_b;
    logic [HOLE_ID_W-1:0]   phole_q, phole_d;
    logic [K_W-1:0]         k;
    logic                   two_plus, push, pop, drop, pocket, fifo_full, fifo_empty;
    logic [PAIR_W-1:0]      fifo_dout;

    assign act_now   = balls_dr & bin_q;
    assign collision = ((act_now & (act_now - 1'b1)) != '0) ||
                       ((act_now != '0) && ((table_dr != 2'd0) || hole_dr));

    // Re-mask in S2 so a ball pocketed on the previous pixel cannot fire again.
    assign act2 = act_q & bin_q;

    always_comb begin
        id_a = '0;
        id_b = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) if (act2[i]) id_a = BALL_ID_W'(i);
        rest       = act2;
        rest[id_a] = 1'b0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) if (rest[i]) id_b = BALL_ID_W'(i);
        two_plus = (rest != '0);
        k        = K_W'(pair_index(32'(id_a), 32'(id_b), NUM_BALLS));
    end

    assign pop = pair_valid && pair_ready;

    always_comb begin
        seen_base = startOfFrame ? '0 : seen_q;
        acc_base  = startOfFrame ? '0 : acc_q;
        side_base = startOfFrame ? '0 : side_q;

        push   = two_plus && !seen_base[k] && !new_game;
        drop   = push && fifo_full && !pop;
        seen_d = seen_base;
        if (two_plus) seen_d[k] = 1'b1;
        ovf_d  = ((startOfFrame ? 1'b0 : ovf_q) | drop);

        hit    = (table_q != WALL_NONE) ? act2 : '0;
        acc_d  = acc_base | hit;
        side_d = side_base;
        for (int i = 0; i < int'(NUM_BALLS); i++)
            if (hit[i] && !acc_base[i]) side_d[2*i +: 2] = table_q;

        pulse_d = (startOfFrame && !new_game) ? acc_q : '0;
        wside_d = (startOfFrame && !new_game) ? side_q : wside_q;

        pocket  = hole_q && (act2 != '0) && !new_game;
        bin_d   = bin_q;
        if (pocket) bin_d[id_a] = 1'b0;
        pv_d    = pocket;
        pball_d = pocket ? id_a : pball_q;
        phole_d = pocket ? hole_id_q : phole_q;

        if (new_game) begin
            bin_d  = '1;
            seen_d = '0;
            acc_d  = '0;
            side_d = '0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            act_q     <= '0;
            table_q   <= WALL_NONE;
            hole_q    <= 1'b0;
            hole_id_q <= '0;
            bin_q     <= '1;
            seen_q    <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            side_q    <= '0;
            pulse_q   <= '0;
            wside_q   <= '0;
            pv_q      <= 1'b0;
            pball_q   <= '0;
            phole_q   <= '0;
        end else begin
            act_q     <= act_now;
            table_q   <= wall_t'(table_dr);
            hole_q    <= hole_dr;
            hole_id_q <= hole_id;
            bin_q     <= bin_d;
            seen_q    <= seen_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
            side_q    <= side_d;
            pulse_q   <= pulse_d;
            wside_q   <= wside_d;
            pv_q      <= pv_d;
            pball_q   <= pball_d;
            phole_q   <= phole_d;
        end
    end

    pair_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk    (clk),
        .resetN (resetN),
        .flush  (new_game),
        .push   (push),
        .din    ({id_a, id_b}),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign pair_valid    = !fifo_empty;
    assign pair_id_a     = fifo_dout[PAIR_W-1:BALL_ID_W];
    assign pair_id_b     = fifo_dout[BALL_ID_W-1:0];
    assign pair_overflow = ovf_q;
    assign wall_pulse    = pulse_q;
    assign wall_side     = wside_q;
    assign balls_in_game = bin_q;
    assign pocket_valid  = pv_q;
    assign pocket_ball   = pball_q;
    assign pocket_hole   = phole_q;

endmodule
